// File: rtl/iic_access_arbiter_if.sv
// Bundles the two requester ports and the shared func-module port of iic_access_arbiter.
// slave is the arbiter's view; master drives requests and the func-module responses.
interface iic_access_arbiter_if;
  logic       Req0;
  logic       Req1;
  logic       Rw0;
  logic       Rw1;
  logic [7:0] Addr0;
  logic [7:0] Addr1;
  logic [7:0] Wd0;
  logic [7:0] Wd1;
  logic       Done0;
  logic       Done1;
  logic [7:0] Rd0;
  logic [7:0] Rd1;
  logic       Err0;
  logic       Err1;
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig;
  logic [7:0] WrData;
  logic       Done_Sig;
  logic [7:0] RdData;
  logic       Busy;

  modport slave (
    input  Req0, Req1, Rw0, Rw1, Addr0, Addr1, Wd0, Wd1, Done_Sig, RdData,
    output Done0, Done1, Rd0, Rd1, Err0, Err1, Start_Sig, Addr_Sig, WrData, Busy
  );

  modport master (
    output Req0, Req1, Rw0, Rw1, Addr0, Addr1, Wd0, Wd1, Done_Sig, RdData,
    input  Done0, Done1, Rd0, Rd1, Err0, Err1, Start_Sig, Addr_Sig, WrData, Busy
  );
endinterface

// File: rtl/iic_access_arbiter.sv
// Round-robin sharing of one iic_func_module between two single-byte requesters,
// with a per-transaction timeout so a hung bus cannot starve the other side.
module iic_access_arbiter #(
  parameter int unsigned TO_W     = 12,
  parameter int unsigned TO_LIMIT = 4000
) (
  input logic                  CLK,
  input logic                  RSTn,
  iic_access_arbiter_if.slave  arb_if
);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TO_LIMIT - 1);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      start_q, start_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic [7:0]      rd0_q, rd0_d;
  logic [7:0]      rd1_q, rd1_d;
  logic            err0_q, err0_d;
  logic            err1_q, err1_d;
  logic            busy_q, busy_d;

  logic       req_any;
  logic       gnt;
  logic       sel_rw;
  logic [7:0] sel_addr;
  logic [7:0] sel_wd;
  logic       timeout;

  assign req_any  = arb_if.Req0 | arb_if.Req1;
  // gnt=1 selects R1: sole requester, or a tie where R0 was granted last.
  assign gnt      = arb_if.Req1 & (~arb_if.Req0 | ~last_q);
  assign sel_rw   = gnt ? arb_if.Rw1   : arb_if.Rw0;
  assign sel_addr = gnt ? arb_if.Addr1 : arb_if.Addr0;
  assign sel_wd   = gnt ? arb_if.Wd1   : arb_if.Wd0;
  assign timeout  = (cnt_q == ToLast);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_any) state_d = StIssue;
      StIssue:   if (arb_if.Done_Sig || timeout) state_d = StRelease;
      StRelease: if (!arb_if.Done_Sig) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    err0_d  = err0_q;
    err1_d  = err1_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          owner_d = gnt;
          last_d  = gnt;
          cnt_d   = '0;
          start_d = sel_rw ? 2'b10 : 2'b01;
          addr_d  = sel_addr;
          wdata_d = sel_wd;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        // Done_Sig wins over a coinciding timeout.
        if (arb_if.Done_Sig) begin
          start_d = 2'b00;
          if (owner_q) begin
            done1_d = 1'b1;
            err1_d  = 1'b0;
            if (start_q == 2'b10) rd1_d = arb_if.RdData;
          end else begin
            done0_d = 1'b1;
            err0_d  = 1'b0;
            if (start_q == 2'b10) rd0_d = arb_if.RdData;
          end
        end else if (timeout) begin
          start_d = 2'b00;
          if (owner_q) begin
            done1_d = 1'b1;
            err1_d  = 1'b1;
            rd1_d   = 8'hFF;
          end else begin
            done0_d = 1'b1;
            err0_d  = 1'b1;
            rd0_d   = 8'hFF;
          end
        end
      end
      StRelease: start_d = 2'b00;
      default:   start_d = 2'b00;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      start_q <= 2'b00;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= 8'h00;
      rd1_q   <= 8'h00;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      busy_q  <= busy_d;
    end
  end

  assign arb_if.Start_Sig = start_q;
  assign arb_if.Addr_Sig  = addr_q;
  assign arb_if.WrData    = wdata_q;
  assign arb_if.Done0     = done0_q;
  assign arb_if.Done1     = done1_q;
  assign arb_if.Rd0       = rd0_q;
  assign arb_if.Rd1       = rd1_q;
  assign arb_if.Err0      = err0_q;
  assign arb_if.Err1      = err1_q;
  assign arb_if.Busy      = busy_q;

endmodule

// File: tb/tb_iic_access_arbiter.sv
// Scoreboard bench: dut_a (default timeout) for normal traffic, dut_b (16-cycle timeout)
// with a func-module model that never answers.
module tb_iic_access_arbiter;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  iic_access_arbiter_if if_a ();
  iic_access_arbiter_if if_b ();

  iic_access_arbiter #(.TO_W(12), .TO_LIMIT(4000)) dut_a (.CLK(CLK), .RSTn(RSTn), .arb_if(if_a));
  iic_access_arbiter #(.TO_W(12), .TO_LIMIT(16))   dut_b (.CLK(CLK), .RSTn(RSTn), .arb_if(if_b));

  // Func-module models: Done_Sig rises so Start_Sig is seen for n cycles (n=0: never).
  int n_a = 20;
  int n_b = 0;
  int mc_a;
  int mc_b;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mc_a <= 0;
      if_a.Done_Sig <= 1'b0;
    end else if (if_a.Start_Sig != 2'b00) begin
      mc_a <= mc_a + 1;
      if (n_a > 1 && mc_a + 1 >= n_a - 1) if_a.Done_Sig <= 1'b1;
    end else begin
      mc_a <= 0;
      if_a.Done_Sig <= 1'b0;
    end
  end

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mc_b <= 0;
      if_b.Done_Sig <= 1'b0;
    end else if (if_b.Start_Sig != 2'b00) begin
      mc_b <= mc_b + 1;
      if (n_b > 1 && mc_b + 1 >= n_b - 1) if_b.Done_Sig <= 1'b1;
    end else begin
      mc_b <= 0;
      if_b.Done_Sig <= 1'b0;
    end
  end

  assign if_a.RdData = if_a.Done_Sig ? (if_a.Addr_Sig ^ 8'h99) : 8'h00;
  assign if_b.RdData = if_b.Done_Sig ? (if_b.Addr_Sig ^ 8'h99) : 8'h00;

  typedef struct {
    int         d;
    int         who;
    logic [1:0] st;
    logic [7:0] addr;
    logic [7:0] wd;
    int         cyc;
    logic       err;
    logic [7:0] rd;
  } exp_t;

  exp_t       q[$];
  logic [7:0] exp_rd [2][2];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input int who, input logic req, input logic rw,
                       input logic [7:0] addr, input logic [7:0] wd);
    if (d == 0 && who == 0) begin
      if_a.Req0 = req; if_a.Rw0 = rw; if_a.Addr0 = addr; if_a.Wd0 = wd;
    end else if (d == 0) begin
      if_a.Req1 = req; if_a.Rw1 = rw; if_a.Addr1 = addr; if_a.Wd1 = wd;
    end else if (who == 0) begin
      if_b.Req0 = req; if_b.Rw0 = rw; if_b.Addr0 = addr; if_b.Wd0 = wd;
    end else begin
      if_b.Req1 = req; if_b.Rw1 = rw; if_b.Addr1 = addr; if_b.Wd1 = wd;
    end
  endtask

  function automatic logic done_of(input int d, input int who);
    if (d == 0) return (who == 0) ? if_a.Done0 : if_a.Done1;
    return (who == 0) ? if_b.Done0 : if_b.Done1;
  endfunction

  // One requester transaction: push expectation, request, wait for DoneX (bounded).
  task automatic txn(input int d, input int who, input logic rw, input logic [7:0] addr,
                     input logic [7:0] wd, input int cyc, input logic to, input int drop,
                     input bit keep);
    exp_t e;
    bit   got;
    e.d    = d;
    e.who  = who;
    e.st   = rw ? 2'b10 : 2'b01;
    e.addr = addr;
    e.wd   = wd;
    e.cyc  = cyc;
    e.err  = to;
    e.rd   = to ? 8'hFF : (rw ? (addr ^ 8'h99) : exp_rd[d][who]);
    exp_rd[d][who] = e.rd;
    q.push_back(e);
    drive(d, who, 1'b1, rw, addr, wd);
    if (drop > 0) begin
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge CLK);
        got = ((d == 0) ? if_a.Start_Sig : if_b.Start_Sig) != 2'b00;
      end
      repeat (drop) @(negedge CLK);
      drive(d, who, 1'b0, rw, addr, wd);
    end
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge CLK);
      got = done_of(d, who);
    end
    chk("done_wait", int'(got), 1);
    if (!keep) drive(d, who, 1'b0, rw, addr, wd);
  endtask

  // Monitor: tracks each Start_Sig burst and pops/compares on every DoneX pulse.
  initial begin
    logic [1:0] ls [2];
    logic [7:0] la [2];
    logic [7:0] lw [2];
    int         lc [2];
    bit         unst [2];
    logic [1:0] st;
    logic [7:0] ad, wdv, r0, r1;
    logic       dn0, dn1, e0, e1;
    exp_t       e;
    lc[0] = 0; lc[1] = 0; unst[0] = 0; unst[1] = 0;
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          st = if_a.Start_Sig; ad = if_a.Addr_Sig; wdv = if_a.WrData; dn0 = if_a.Done0;
          dn1 = if_a.Done1; r0 = if_a.Rd0; r1 = if_a.Rd1; e0 = if_a.Err0; e1 = if_a.Err1;
        end else begin
          st = if_b.Start_Sig; ad = if_b.Addr_Sig; wdv = if_b.WrData; dn0 = if_b.Done0;
          dn1 = if_b.Done1; r0 = if_b.Rd0; r1 = if_b.Rd1; e0 = if_b.Err0; e1 = if_b.Err1;
        end
        if (!RSTn) begin
          lc[d] = 0;
          unst[d] = 0;
          continue;
        end
        if (st == 2'b11) chk("start_11", int'(st), 0);
        if (st != 2'b00) begin
          if (lc[d] == 0) begin
            ls[d] = st; la[d] = ad; lw[d] = wdv;
          end else if (st != ls[d] || ad != la[d] || wdv != lw[d]) begin
            unst[d] = 1;
          end
          lc[d]++;
        end
        if (dn0 || dn1) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_dut", d, e.d);
            chk("grant_who", int'(dn1), e.who);
            chk("both_done", int'(dn0 & dn1), 0);
            chk("start_kind", int'(ls[d]), int'(e.st));
            chk("addr_sig", int'(la[d]), int'(e.addr));
            chk("wrdata", int'(lw[d]), int'(e.wd));
            chk("start_cycles", lc[d], e.cyc);
            chk("start_stable", int'(unst[d]), 0);
            chk("start_dropped", int'(st), 0);
            chk("err", int'(dn1 ? e1 : e0), int'(e.err));
            chk("rd", int'(dn1 ? r1 : r0), int'(e.rd));
          end
          lc[d] = 0;
          unst[d] = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 2; w++) begin
        drive(d, w, 1'b0, 1'b0, 8'h00, 8'h00);
        exp_rd[d][w] = 8'h00;
      end
    end
    RSTn = 1'b1;
    #2 RSTn = 1'b0;
    #1;
    chk("rst_start", int'(if_a.Start_Sig), 0);
    chk("rst_addr", int'(if_a.Addr_Sig), 0);
    chk("rst_wrdata", int'(if_a.WrData), 0);
    chk("rst_done", int'({if_a.Done0, if_a.Done1}), 0);
    chk("rst_rd", int'({if_a.Rd0, if_a.Rd1}), 0);
    chk("rst_err", int'({if_a.Err0, if_a.Err1}), 0);
    chk("rst_busy", int'(if_a.Busy), 0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    // 1: R0 write AA/55, model answers after 20 cycles.
    n_a = 20;
    fork
      txn(0, 0, 1'b0, 8'hAA, 8'h55, 20, 1'b0, 0, 1'b0);
      begin
        repeat (5) @(negedge CLK);
        chk("busy_issue", int'(if_a.Busy), 1);
      end
    join
    repeat (4) @(negedge CLK);
    chk("busy_after_t1", int'(if_a.Busy), 0);
    chk("rd0_unchanged", int'(if_a.Rd0), 8'h00);

    // 2: R1 read 3C -> A5.
    n_a = 6;
    txn(0, 1, 1'b1, 8'h3C, 8'h00, 6, 1'b0, 0, 1'b0);
    chk("rd1_a5", int'(if_a.Rd1), 8'hA5);

    // 3: both request continuously, six grants alternating from R0.
    n_a = 4;
    fork
      begin
        txn(0, 0, 1'b1, 8'h10, 8'h00, 4, 1'b0, 0, 1'b1);
        txn(0, 0, 1'b0, 8'h11, 8'h22, 4, 1'b0, 0, 1'b1);
        txn(0, 0, 1'b1, 8'h12, 8'h00, 4, 1'b0, 0, 1'b0);
      end
      begin
        #1;
        txn(0, 1, 1'b0, 8'h20, 8'h33, 4, 1'b0, 0, 1'b1);
        txn(0, 1, 1'b1, 8'h21, 8'h00, 4, 1'b0, 0, 1'b1);
        txn(0, 1, 1'b0, 8'h22, 8'h44, 4, 1'b0, 0, 1'b0);
      end
    join
    repeat (6) @(negedge CLK);

    // 4: dut_b never answered -> timeout after 16 cycles, then R1 served normally.
    n_b = 0;
    txn(1, 0, 1'b1, 8'h77, 8'h00, 16, 1'b1, 0, 1'b0);
    chk("err0_timeout", int'(if_b.Err0), 1);
    n_b = 5;
    repeat (4) @(negedge CLK);
    txn(1, 1, 1'b1, 8'h12, 8'h00, 5, 1'b0, 0, 1'b0);
    chk("rd1_after_to", int'(if_b.Rd1), 8'h8B);
    chk("err0_held", int'(if_b.Err0), 1);
    chk("rd0_held", int'(if_b.Rd0), 8'hFF);

    // 5: reset in the middle of a read.
    n_a = 20;
    drive(0, 0, 1'b1, 1'b1, 8'h3C, 8'h00);
    repeat (6) @(negedge CLK);
    chk("t5_started", int'(if_a.Start_Sig), 2'b10);
    #2 RSTn = 1'b0;
    #1;
    chk("t5_start_async", int'(if_a.Start_Sig), 0);
    chk("t5_busy_async", int'(if_a.Busy), 0);
    drive(0, 0, 1'b0, 1'b1, 8'h3C, 8'h00);
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 2; w++) exp_rd[d][w] = 8'h00;
    end
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    n_a = 4;
    fork
      txn(0, 0, 1'b0, 8'h01, 8'h02, 4, 1'b0, 0, 1'b0);
      begin
        #1;
        txn(0, 1, 1'b0, 8'h03, 8'h04, 4, 1'b0, 0, 1'b0);
      end
    join
    repeat (6) @(negedge CLK);

    // 6: requester drops Req two cycles after grant.
    n_a = 10;
    txn(0, 1, 1'b1, 8'h5A, 8'h00, 10, 1'b0, 2, 1'b0);
    repeat (8) @(negedge CLK);
    chk("t6_busy_idle", int'(if_a.Busy), 0);
    chk("t6_no_regrant", int'(if_a.Start_Sig), 0);
    chk("rd1_c3", int'(if_a.Rd1), 8'hC3);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
